// File: rtl/i2c_slave.sv
// I2C target exposing an 8x8-bit register bank with pointer-based writes and sequential reads.
// Optional macro I2C_SLAVE_AUTOINC_EN: pointer advances after each written byte and each ACKed read byte.
module i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SCL,
    input  logic        SDA,
    output logic        SDA_oe_top,
    output logic        SDA_reg_top,
    output logic [63:0] regs_out,
    output logic        rx_valid,
    output logic [2:0]  rx_addr,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_MEM_ADDR,
        S_MEM_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [63:0] regs_q, regs_d;
    logic        oe_q, oe_d;
    logic        ack_ph_q, ack_ph_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        rx_valid_q, rx_valid_d;
    logic [2:0]  rx_addr_q, rx_addr_d;

    logic       scl_rise, scl_fall, start_det, stop_det, last_bit;
    logic [7:0] byte_in, reg_cur, reg_next;
    logic [2:0] ptr_adv;

    // Synchronizers reset to the idle-high bus level so reset release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & ~sda_d & sda_s2;
    assign last_bit  = (bit_cnt_q == 3'd7);
    assign byte_in   = {shift_q[6:0], sda_s2};

`ifdef I2C_SLAVE_AUTOINC_EN
    assign ptr_adv = ptr_q + 3'd1;
`else
    assign ptr_adv = ptr_q;
`endif

    assign reg_cur  = regs_q[{ptr_q, 3'b000} +: 8];
    assign reg_next = regs_q[{ptr_adv, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 8'd0;
            ptr_q      <= 3'd0;
            regs_q     <= 64'd0;
            oe_q       <= 1'b0;
            ack_ph_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_addr_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            regs_q     <= regs_d;
            oe_q       <= oe_d;
            ack_ph_q   <= ack_ph_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_addr_q  <= rx_addr_d;
        end
    end

    // START/STOP take priority over any SCL edge seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        oe_d       = oe_q;
        ack_ph_d   = ack_ph_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_addr_d  = rx_addr_q;

        if (stop_det) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            oe_d     = 1'b0;
            ack_ph_d = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            shift_d   = 8'd0;
            oe_d      = 1'b0;
            ack_ph_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = byte_in[0];
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                // First fall after bit 8 pulls SDA low; the fall ending the 9th clock releases it.
                S_ADDR_ACK, S_MEM_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            oe_d     = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            ack_ph_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d = S_RD_DATA;
                                oe_d    = ~reg_cur[7];
                                tx_d    = {reg_cur[6:0], 1'b0};
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_MEM_ADDR;
                            end else begin
                                state_d = S_WR_DATA;
                            end
                        end
                    end
                end
                S_MEM_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            ptr_d   = byte_in[2:0];
                            state_d = S_MEM_ACK;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            regs_d[{ptr_q, 3'b000} +: 8] = byte_in;
                            rx_valid_d = 1'b1;
                            rx_addr_d  = ptr_q;
                            ptr_d      = ptr_adv;
                            state_d    = S_WR_ACK;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            state_d = S_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        oe_d = ~tx_q[7];
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
                S_RD_ACK: begin
                    if (scl_fall) begin
                        oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_s2) begin
                            ptr_d     = ptr_adv;
                            tx_d      = reg_next;
                            bit_cnt_d = 3'd0;
                            state_d   = S_RD_DATA;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SDA_oe_top  = oe_q;
    assign SDA_reg_top = 1'b0;
    assign regs_out    = regs_q;
    assign rx_valid    = rx_valid_q;
    assign rx_addr     = rx_addr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a register-bank reference model.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam logic [6:0] DEV = 7'h42;
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_line;
    logic        SDA_oe_top, SDA_reg_top, rx_valid, busy;
    logic [63:0] regs_out;
    logic [2:0]  rx_addr;

    assign sda_line = m_sda & (SDA_oe_top ? SDA_reg_top : 1'b1);

    i2c_slave #(.DEV_ADDR(DEV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SCL        (m_scl),
        .SDA        (sda_line),
        .SDA_oe_top (SDA_oe_top),
        .SDA_reg_top(SDA_reg_top),
        .regs_out   (regs_out),
        .rx_valid   (rx_valid),
        .rx_addr    (rx_addr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rx_log[$];
    int exp_rx[$];
    logic [7:0] mregs [8];
    int mptr;

    // Record every write strobe seen by the robot side, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back(int'(rx_addr));
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] modelRegs();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = mregs[k];
        return r;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 8; k++) mregs[k] = 8'h00;
        mptr = 0;
    endtask

    task automatic modelWrite(input int mem, input int n, input logic [31:0] data);
        mptr = mem;
        for (int i = 0; i < n; i++) begin
            mregs[mptr] = data[8*i +: 8];
            exp_rx.push_back(mptr);
            if (AUTOINC) mptr = (mptr + 1) % 8;
        end
    endtask

    task automatic modelRead(input bit acked, output logic [7:0] b);
        b = mregs[mptr];
        if (acked && AUTOINC) mptr = (mptr + 1) % 8;
    endtask

    // ---------------- bus-level controller tasks ----------------
    task automatic busStart();
        waitClk(3); m_sda = 1'b1;
        waitClk(7); m_scl = 1'b1;
        waitClk(10); m_sda = 1'b0;
        waitClk(10); m_scl = 1'b0;
    endtask

    task automatic busStop();
        waitClk(3); m_sda = 1'b0;
        waitClk(7); m_scl = 1'b1;
        waitClk(10); m_sda = 1'b1;
        waitClk(10);
    endtask

    task automatic busWriteBit(input logic b);
        waitClk(3); m_sda = b;
        waitClk(7); m_scl = 1'b1;
        waitClk(10); m_scl = 1'b0;
    endtask

    task automatic busReadBit(output logic b);
        waitClk(3); m_sda = 1'b1;
        waitClk(7); m_scl = 1'b1;
        waitClk(8); b = sda_line;
        waitClk(2); m_scl = 1'b0;
    endtask

    task automatic busWriteByte(input logic [7:0] d, output bit ack);
        logic x;
        for (int i = 7; i >= 0; i--) busWriteBit(d[i]);
        busReadBit(x);
        ack = ~x;
    endtask

    task automatic busReadByte(output logic [7:0] d, input bit nack);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            busReadBit(x);
            d[i] = x;
        end
        busWriteBit(nack);
    endtask

    // Full write transaction: address, register index, then n data bytes, then STOP.
    task automatic doWrite(input logic [6:0] dev, input logic [2:0] mem, input int n,
                           input logic [31:0] data, output bit addr_ack, output logic busy_mid,
                           output int bad_acks);
        bit a;
        bad_acks = 0;
        busStart();
        busWriteByte({dev, 1'b0}, addr_ack);
        waitClk(6);
        busy_mid = busy;
        if (addr_ack) begin
            busWriteByte({5'($urandom), mem}, a);
            if (!a) bad_acks++;
            for (int i = 0; i < n; i++) begin
                busWriteByte(data[8*i +: 8], a);
                if (!a) bad_acks++;
            end
        end
        busStop();
    endtask

    task automatic doRead(input int n, output bit addr_ack, output logic [31:0] data);
        logic [7:0] b;
        data = 32'd0;
        busStart();
        busWriteByte({DEV, 1'b1}, addr_ack);
        if (addr_ack) begin
            for (int i = 0; i < n; i++) begin
                busReadByte(b, (i == n - 1));
                data[8*i +: 8] = b;
            end
        end
        busStop();
    endtask

    task automatic checkRxLog(input string name);
        checkOutput({name, "_rx_count"}, 64'(rx_log.size()), 64'(exp_rx.size()));
        for (int i = 0; i < rx_log.size() && i < exp_rx.size(); i++)
            checkOutput({name, "_rx_addr"}, 64'(rx_log[i]), 64'(exp_rx[i]));
        rx_log.delete();
        exp_rx.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [6:0]  dev;
        logic [2:0]  mem;
        int          nwr;
        logic [15:0] data;
        bit          exp_ack;
        logic [63:0] exp_regs;
        int          exp_rx_n;
        int          exp_rx0;
        int          exp_rx1;
    } vec_t;

    vec_t vecs[4];

    task automatic applyStimulus(input vec_t v, input int idx);
        bit a;
        logic bm;
        int bad;
        string tag;
        tag = $sformatf("vec%0d", idx);
        doWrite(v.dev, v.mem, v.nwr, {16'd0, v.data}, a, bm, bad);
        if (v.exp_ack) modelWrite(int'(v.mem), v.nwr, {16'd0, v.data});
        checkOutput({tag, "_addr_ack"}, 64'(a), 64'(v.exp_ack));
        checkOutput({tag, "_busy_mid"}, 64'(bm), 64'(v.exp_ack));
        checkOutput({tag, "_bad_acks"}, 64'(bad), 64'd0);
        checkOutput({tag, "_regs"}, regs_out, v.exp_regs);
        checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
        checkOutput({tag, "_rx_count"}, 64'(rx_log.size()), 64'(v.exp_rx_n));
        if (v.exp_rx_n > 0 && rx_log.size() > 0)
            checkOutput({tag, "_rx_addr0"}, 64'(rx_log[0]), 64'(v.exp_rx0));
        if (v.exp_rx_n > 1 && rx_log.size() > 1)
            checkOutput({tag, "_rx_addr1"}, 64'(rx_log[1]), 64'(v.exp_rx1));
        rx_log.delete();
        exp_rx.delete();
    endtask

    initial begin
        bit a;
        logic bm;
        int bad;
        logic [31:0] rd;
        logic [7:0] b, eb;

        vecs[0] = '{DEV, 3'd2, 2, 16'h3CA5, 1'b1,
                    AUTOINC ? 64'h00000000_3CA50000 : 64'h00000000_003C0000, 2, 2, AUTOINC ? 3 : 2};
        vecs[1] = '{7'h21, 3'd5, 1, 16'h0077, 1'b0,
                    AUTOINC ? 64'h00000000_3CA50000 : 64'h00000000_003C0000, 0, 0, 0};
        vecs[2] = '{DEV, 3'd7, 2, 16'h2211, 1'b1,
                    AUTOINC ? 64'h11000000_3CA50022 : 64'h22000000_003C0000, 2, 7, AUTOINC ? 0 : 7};
        vecs[3] = '{DEV, 3'd4, 1, 16'h0080, 1'b1,
                    AUTOINC ? 64'h11000080_3CA50022 : 64'h22000080_003C0000, 1, 4, 0};

        modelReset();
        waitClk(5);
        checkOutput("reset_oe", 64'(SDA_oe_top), 64'd0);
        checkOutput("reset_regs", regs_out, 64'd0);
        rst_n = 1'b1;
        waitClk(10);
        checkOutput("idle_oe", 64'(SDA_oe_top), 64'd0);
        checkOutput("idle_sda_reg", 64'(SDA_reg_top), 64'd0);
        checkOutput("idle_regs", regs_out, 64'd0);
        checkOutput("idle_rx_valid", 64'(rx_valid), 64'd0);
        checkOutput("idle_rx_addr", 64'(rx_addr), 64'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

        // Pointer set by an index-only write, then a two-byte read ending in NACK.
        doWrite(DEV, 3'd2, 0, 32'd0, a, bm, bad);
        modelWrite(2, 0, 32'd0);
        busStart();
        busWriteByte({DEV, 1'b1}, a);
        checkOutput("rd_addr_ack", 64'(a), 64'd1);
        waitClk(6);
        checkOutput("rd_busy_mid", 64'(busy), 64'd1);
        for (int i = 0; i < 2; i++) begin
            busReadByte(b, (i == 1));
            modelRead(i == 0, eb);
            checkOutput($sformatf("rd_byte%0d", i), 64'(b), 64'(eb));
        end
        waitClk(6);
        checkOutput("rd_released_after_nack", 64'(SDA_oe_top), 64'd0);
        busStop();
        checkOutput("rd_busy_end", 64'(busy), 64'd0);
        checkRxLog("rd");

        // Repeated START after one written byte, then a one-byte read.
        busStart();
        busWriteByte({DEV, 1'b0}, a);
        busWriteByte(8'h01, a);
        busWriteByte(8'h55, a);
        checkOutput("rs_data_ack", 64'(a), 64'd1);
        modelWrite(1, 1, 32'h55);
        busStart();
        busWriteByte({DEV, 1'b1}, a);
        checkOutput("rs_addr_ack", 64'(a), 64'd1);
        busReadByte(b, 1'b1);
        modelRead(1'b0, eb);
        checkOutput("rs_read_byte", 64'(b), 64'(eb));
        busStop();
        checkOutput("rs_regs", regs_out, modelRegs());
        checkRxLog("rs");

        // Reset asserted while the target is driving a 0 data bit.
        doWrite(DEV, 3'd5, 1, 32'h0F, a, bm, bad);
        modelWrite(5, 1, 32'h0F);
        doWrite(DEV, 3'd5, 0, 32'd0, a, bm, bad);
        modelWrite(5, 0, 32'd0);
        rx_log.delete();
        exp_rx.delete();
        busStart();
        busWriteByte({DEV, 1'b1}, a);
        waitClk(6);
        checkOutput("rst_pre_drive_low", 64'(SDA_oe_top), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_oe", 64'(SDA_oe_top), 64'd0);
        checkOutput("rst_regs", regs_out, 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_rx_valid", 64'(rx_valid), 64'd0);
        modelReset();
        waitClk(3);
        m_scl = 1'b1;
        m_sda = 1'b1;
        waitClk(5);
        rst_n = 1'b1;
        waitClk(10);
        doWrite(DEV, 3'd3, 1, 32'h99, a, bm, bad);
        modelWrite(3, 1, 32'h99);
        checkOutput("post_rst_ack", 64'(a), 64'd1);
        checkOutput("post_rst_regs", regs_out, modelRegs());
        doRead(1, a, rd);
        modelRead(1'b0, eb);
        checkOutput("post_rst_read", 64'(rd[7:0]), 64'(eb));
        checkRxLog("post_rst");

        // Randomized transactions against the model.
        for (int t = 0; t < 20; t++) begin
            int kind;
            int n;
            logic [6:0] dev;
            logic [2:0] mem;
            logic [31:0] data;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                dev = 7'($urandom_range(0, 127));
                if (dev == DEV) dev = 7'h21;
                doWrite(dev, 3'd0, 1, 32'($urandom), a, bm, bad);
                checkOutput("rnd_wrong_addr_nack", 64'(a), 64'd0);
                checkOutput("rnd_wrong_addr_busy", 64'(bm), 64'd0);
            end else if (kind <= 5) begin
                mem  = 3'($urandom_range(0, 7));
                n    = int'($urandom_range(0, 3));
                data = $urandom;
                doWrite(DEV, mem, n, data, a, bm, bad);
                modelWrite(int'(mem), n, data);
                checkOutput("rnd_wr_ack", 64'(a), 64'd1);
                checkOutput("rnd_wr_bad_acks", 64'(bad), 64'd0);
            end else begin
                n = int'($urandom_range(1, 3));
                doRead(n, a, rd);
                checkOutput("rnd_rd_ack", 64'(a), 64'd1);
                for (int i = 0; i < n; i++) begin
                    modelRead(i != n - 1, eb);
                    checkOutput("rnd_rd_byte", 64'(rd[8*i +: 8]), 64'(eb));
                end
            end
            checkOutput("rnd_regs", regs_out, modelRegs());
            checkOutput("rnd_busy_end", 64'(busy), 64'd0);
            checkRxLog("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (responder) that lets an external I2C controller read and write an 8×8-bit register bank over the same SCL/SDA pins the robot's I2C controller uses. It watches SCL/SDA, detects START/STOP, matches its 7-bit device address, and supports register writes (address byte then data) and sequential reads from the current pointer. It exposes the bank as a 64-bit bus plus a per-byte write strobe to the robot control logic, and drives SDA through the top-level tristate.

## Interface
- DEV_ADDR, 7'h42, 7-bit device address this target answers to
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- SCL  input  1  bus clock from pin
- SDA  input  1  bus data from pin
- SDA_oe_top  output  1  1 = drive SDA pin with SDA_reg_top
- SDA_reg_top  output  1  value driven when enabled; held 0 (open-drain)
- regs_out  output  64  register bank, reg k at [8k+7:8k]
- rx_valid  output  1  one-cycle pulse per data byte written by the bus
- rx_addr  output  3  register index written when rx_valid=1
- busy  output  1  1 between an addressed START and the following STOP

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, then a third flop for edge detection. All decisions use synchronized values.
- START: SDA falls while SCL is high. Valid in any state, including repeated START. Effects: bit counter=0, shift reg=0, state=ADDR, SDA released.
- STOP: SDA rises while SCL is high. Valid in any state. Effects: state=IDLE, busy=0, SDA released.
- Data bits are sampled on the synchronized SCL rising edge, MSB first. The target changes SDA only on the synchronized SCL falling edge.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If bits[7:1]==DEV_ADDR, go to ADDR_ACK and set busy=1.
    - Otherwise go to IGNORE, which waits for START/STOP with SDA released.
  - ADDR_ACK: drive ACK for the 9th clock. Then:
    - R/W=0: go to MEM_ADDR.
    - R/W=1: load the read shift register with reg[ptr], go to RD_DATA.
  - MEM_ADDR: shift 8 bits. ptr<=bits[2:0] (bits[7:3] ignored). Go to MEM_ACK (ACK), then WR_DATA.
  - WR_DATA: shift 8 bits. reg[ptr]<=byte, pulse rx_valid with rx_addr=ptr, advance ptr. Go to WR_ACK (ACK), then back to WR_DATA.
  - RD_DATA: drive 8 bits of the shift register. Go to RD_ACK and release SDA.
  - RD_ACK: sample the controller's bit on the SCL rise.
    - 0 (ACK): advance ptr, load reg[ptr], go to RD_DATA.
    - 1 (NACK): go to IGNORE until STOP/START.
- ACK drive rules:
  - Asserted on the SCL falling edge that ends bit 8: SDA_oe_top=1.
  - Released on the falling edge that ends the 9th clock.
- Read bit drive: SDA_oe_top = ~bit (a 0 is driven low, a 1 is released).
- Pointer advance: ptr+1 modulo 8. ptr keeps its value across transactions.
- Reset values:
  - regs_out = 0, ptr = 0, state = IDLE.
  - SDA_oe_top = 0, SDA_reg_top = 0, rx_valid = 0, rx_addr = 0, busy = 0.
- Reset asserted mid-transaction: all outputs return to their reset values immediately. SDA is released.

## Timing
- Pin-to-decision latency: 3 clk. The bus must hold each SCL phase for at least 4 clk; the robot controller uses ~250 clk.
- rx_valid rises 1 clk after the synchronized SCL rising edge that samples the 8th data bit. regs_out updates in the same cycle.
- SDA output changes 1 clk after the synchronized SCL fall is detected, well before the next SCL rise.
- START or STOP detected in the same cycle as an SCL edge: START/STOP wins and the edge is ignored.

## Configuration
- Macro: I2C_SLAVE_AUTOINC_EN.
- Defined: ptr advances after every written byte and every ACKed read byte, wrapping 7→0.
- Not defined: ptr changes only in MEM_ADDR. Every data byte of a transaction targets the same register.

## Test plan
- Write DEV_ADDR+W, mem 0x02, data 0xA5, 0x3C, STOP. Expected:
  - ACK on all three bytes.
  - regs_out[23:16]=0xA5 and regs_out[31:24]=0x3C.
  - Two rx_valid pulses with rx_addr 2 then 3.
- Preload regs 2,3 = 0xA5,0x3C, set ptr=2 (write with mem byte only), then read DEV_ADDR+R for 2 bytes (ACK, NACK). Expected: bus bytes 0xA5 then 0x3C, SDA released after the NACK, busy=0 after STOP.
- Address 0x21+W when DEV_ADDR=0x42. Expected: NACK (SDA released on the 9th clock), no register change, busy stays 0.
- Write at mem 0x07 with data 0x11, 0x22. Expected: reg7=0x11, reg0=0x22 (wrap). With the macro undefined: reg7=0x22 and reg0 unchanged.
- Repeated START mid-write (after byte 0x55 to reg 1) followed by a read. Expected: the read returns reg2 (autoinc). No state corruption; rx_valid fired exactly once.
- rst_n low during RD_DATA while SDA is driven low. Expected: SDA_oe_top=0 immediately, regs_out=0, the next transaction starts from IDLE.
